// File: rtl/des_engine_arbiter.sv
// ============================================================================
// des_engine_arbiter : round-robin sharing of one DES engine between two ports
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module des_engine_arbiter #(
  parameter int TIMEOUT  = 32,
  parameter int FLUSH    = 20,
  parameter int ENG_COMB = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_data,
  input  logic [63:0] req0_key,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_data,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_data,
  input  logic [63:0] req1_key,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_data,
  output logic        rsp1_err,
  output logic [63:0] eng_data,
  output logic [63:0] eng_key,
  output logic        eng_data_vld,
  input  logic [63:0] eng_result,
  input  logic        eng_result_vld
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam int FC_W = (FLUSH > 0) ? $clog2(FLUSH + 1) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'((FLUSH > 0) ? FLUSH - 1 : 0);
  localparam bit COMB = (ENG_COMB != 0);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]      state;
  logic [FC_W-1:0] flush_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic            rr_ptr;
  logic            owner;
  logic [63:0]     data_q;
  logic [63:0]     key_q;
  logic [63:0]     result_q;
  logic            err_q;

  logic idle;
  logic grant0;
  logic grant1;
  logic take;
  logic rsp_done;

  // rr_ptr names the port that wins a tie; a lone requester always wins
  assign idle     = (state == S_IDLE);
  assign grant1   = req1_valid & (~req0_valid | rr_ptr);
  assign grant0   = req0_valid & (~req1_valid | ~rr_ptr);
  assign take     = idle & (req0_valid | req1_valid);
  assign rsp_done = owner ? rsp1_ready : rsp0_ready;

  assign req0_ready   = idle & grant0;
  assign req1_ready   = idle & grant1;
  assign rsp0_valid   = (state == S_RESP) & ~owner;
  assign rsp1_valid   = (state == S_RESP) & owner;
  assign rsp0_data    = result_q;
  assign rsp1_data    = result_q;
  assign rsp0_err     = err_q;
  assign rsp1_err     = err_q;
  assign eng_data     = data_q;
  assign eng_key      = key_q;
  assign eng_data_vld = (state == S_LAUNCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      data_q    <= '0;
      key_q     <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        // Engine has no reset; stale strobes during this window are dropped
        S_INIT: begin
          if (flush_cnt >= FLUSH_LAST) begin
            state <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (take) begin
            data_q <= grant1 ? req1_data : req0_data;
            key_q  <= grant1 ? req1_key  : req0_key;
            owner  <= grant1;
            rr_ptr <= ~grant1;
            state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          if (COMB && eng_result_vld) begin
            result_q <= eng_result;
            err_q    <= 1'b0;
            state    <= S_RESP;
          end else begin
            state <= S_WAIT;
          end
        end
        // A result arriving on the timeout cycle takes precedence
        S_WAIT: begin
          if (eng_result_vld) begin
            result_q <= eng_result;
            err_q    <= 1'b0;
            state    <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_des_engine_arbiter.sv
// ============================================================================
// tb_des_engine_arbiter : directed self-checking bench for des_engine_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_engine_arbiter;

  localparam logic [63:0] FIPS_KEY = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] FIPS_PT  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FIPS_CT  = 64'h85E8_1354_0F0A_B405;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [63:0] req0_data, req0_key, rsp0_data;
  logic [63:0] req1_data, req1_key, rsp1_data;
  logic [63:0] eng_data, eng_key;
  logic        eng_data_vld;
  logic [63:0] eng_result = '0;
  logic        eng_result_vld = 1'b0;

  logic        c_req0_valid, c_req0_ready, c_rsp0_valid, c_rsp0_ready, c_rsp0_err;
  logic        c_req1_valid, c_req1_ready, c_rsp1_valid, c_rsp1_ready, c_rsp1_err;
  logic [63:0] c_req0_data, c_req0_key, c_rsp0_data;
  logic [63:0] c_req1_data, c_req1_key, c_rsp1_data;
  logic [63:0] c_eng_data, c_eng_key;
  logic        c_eng_data_vld;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  des_engine_arbiter #(.TIMEOUT(32), .FLUSH(20), .ENG_COMB(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .eng_data(eng_data), .eng_key(eng_key), .eng_data_vld(eng_data_vld),
    .eng_result(eng_result), .eng_result_vld(eng_result_vld)
  );

  des_engine_arbiter #(.TIMEOUT(32), .FLUSH(20), .ENG_COMB(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(c_req0_valid), .req0_ready(c_req0_ready), .req0_data(c_req0_data), .req0_key(c_req0_key),
    .rsp0_valid(c_rsp0_valid), .rsp0_ready(c_rsp0_ready), .rsp0_data(c_rsp0_data), .rsp0_err(c_rsp0_err),
    .req1_valid(c_req1_valid), .req1_ready(c_req1_ready), .req1_data(c_req1_data), .req1_key(c_req1_key),
    .rsp1_valid(c_rsp1_valid), .rsp1_ready(c_rsp1_ready), .rsp1_data(c_rsp1_data), .rsp1_err(c_rsp1_err),
    .eng_data(c_eng_data), .eng_key(c_eng_key), .eng_data_vld(c_eng_data_vld),
    .eng_result(c_eng_data), .eng_result_vld(c_eng_data_vld)
  );

  // Engine model: 17 cycles launch-to-strobe, no reset, optional hang.
  // Returns the FIPS vector for the known pair, data^key otherwise.
  logic       eng_hang = 1'b0;
  logic       eng_pend = 1'b0;
  logic [4:0] eng_dly  = '0;

  always @(posedge clk) begin
    eng_result_vld <= 1'b0;
    if (eng_data_vld && !eng_hang) begin
      eng_pend   <= 1'b1;
      eng_dly    <= 5'd15;
      eng_result <= (eng_data == FIPS_PT && eng_key == FIPS_KEY) ? FIPS_CT : (eng_data ^ eng_key);
    end else if (eng_pend) begin
      if (eng_dly == 5'd0) begin
        eng_result_vld <= 1'b1;
        eng_pend       <= 1'b0;
      end else begin
        eng_dly <= eng_dly - 5'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on one port and confirm it is granted this cycle.
  task automatic issue(input int port, input logic [63:0] d, input logic [63:0] k, input string tag);
    if (port == 0) begin
      req0_data = d; req0_key = k; req0_valid = 1'b1;
    end else begin
      req1_data = d; req1_key = k; req1_valid = 1'b1;
    end
    #1;
    check(tag, (port == 0) ? req0_ready : req1_ready, 64'd1);
  endtask

  // Clock from the handshake cycle until the port's response is valid.
  task automatic run_to_rsp(input int port, output int lat, output int launches);
    lat = 0;
    launches = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (eng_data_vld) launches++;
    end while (!((port == 0) ? rsp0_valid : rsp1_valid) && lat < 200);
  endtask

  task automatic consume(input int port);
    if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic wait_ready0(output int n, output int saw_rsp, output int saw_strobe);
    n = 0;
    saw_rsp = 0;
    saw_strobe = 0;
    while (!req0_ready && n < 100) begin
      tick();
      n++;
      if (rsp0_valid || rsp1_valid) saw_rsp++;
      if (eng_result_vld) saw_strobe++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nl, n, saw_rsp, saw_strobe, g;
    logic [63:0] exp;

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = '0; req0_key = '0; rsp0_ready = 1'b0;
    req1_valid = 1'b1; req1_data = '0; req1_key = '0; rsp1_ready = 1'b0;
    c_req0_valid = 1'b0; c_req0_data = '0; c_req0_key = '0; c_rsp0_ready = 1'b0;
    c_req1_valid = 1'b0; c_req1_data = '0; c_req1_key = '0; c_rsp1_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_eng_vld", eng_data_vld, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_rsp0_err", rsp0_err, 0);
    req1_valid = 1'b0;
    rst_n = 1'b1;
    wait_ready0(n, saw_rsp, saw_strobe);
    check("flush_len", n, 20);

    // 1: FIPS vector on port 0
    issue(0, FIPS_PT, FIPS_KEY, "t1_grant");
    tick();
    check("t1_eng_vld", eng_data_vld, 1);
    check("t1_eng_data", eng_data, FIPS_PT);
    check("t1_eng_key", eng_key, FIPS_KEY);
    begin
      int lat2, nl2;
      run_to_rsp(0, lat2, nl2);
      check("t1_latency", lat2 + 1, 19);
      check("t1_launches", nl2, 0);
    end
    check("t1_rsp0_data", rsp0_data, FIPS_CT);
    check("t1_rsp0_err", rsp0_err, 0);
    check("t1_rsp1_valid", rsp1_valid, 0);
    consume(0);
    check("t1_rsp0_cleared", rsp0_valid, 0);

    // 3: hung engine -> timeout, then a normal job
    eng_hang = 1'b1;
    issue(0, 64'hDEAD_BEEF_0000_1111, 64'h0F0F_0F0F_0F0F_0F0F, "t3_grant");
    run_to_rsp(0, lat, nl);
    check("t3_latency", lat, 34);
    check("t3_launches", nl, 1);
    check("t3_err", rsp0_err, 1);
    check("t3_data", rsp0_data, 0);
    eng_hang = 1'b0;
    consume(0);
    issue(1, 64'h1111_2222_3333_4444, 64'hFFFF_0000_FFFF_0000, "t3_next_grant");
    run_to_rsp(1, lat, nl);
    check("t3_next_latency", lat, 19);
    check("t3_next_data", rsp1_data, 64'hEEEE_2222_CCCC_4444);
    check("t3_next_err", rsp1_err, 0);
    check("t3_next_rsp0", rsp0_valid, 0);
    consume(1);

    // 4: response back-pressure blocks the other port
    issue(0, 64'hAAAA_AAAA_5555_5555, 64'h0000_FFFF_0000_FFFF, "t4_grant");
    run_to_rsp(0, lat, nl);
    check("t4_latency", lat, 19);
    req1_data = 64'h0102_0304_0506_0708; req1_key = 64'h1010_1010_1010_1010; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_hold_ready1", req1_ready, 0);
      check("t4_hold_valid", rsp0_valid, 1);
      check("t4_hold_data", rsp0_data, 64'hAAAA_5555_5555_AAAA);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check("t4_consume_ready1", req1_ready, 0);
    tick();
    rsp0_ready = 1'b0;
    #1;
    check("t4_after_ready1", req1_ready, 1);
    check("t4_after_rsp0", rsp0_valid, 0);
    run_to_rsp(1, lat, nl);
    check("t4_p1_latency", lat, 19);
    check("t4_p1_data", rsp1_data, 64'h1112_1314_1516_1718);
    consume(1);

    // 2: four ties alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      req0_data = 64'h0A0A_0000_0000_0000 + 64'(i); req0_key = 64'h0000_FFFF_0000_0000;
      req1_data = 64'hB0B0_0000_0000_0000 + 64'(i); req1_key = 64'h0000_0000_FFFF_0000;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      g = i % 2;
      check("t2_ready0", req0_ready, (g == 0) ? 64'd1 : 64'd0);
      check("t2_ready1", req1_ready, (g == 1) ? 64'd1 : 64'd0);
      exp = (g == 1) ? (req1_data ^ req1_key) : (req0_data ^ req0_key);
      run_to_rsp(g, lat, nl);
      check("t2_latency", lat, 19);
      check("t2_data", (g == 1) ? rsp1_data : rsp0_data, exp);
      check("t2_other_valid", (g == 1) ? rsp0_valid : rsp1_valid, 0);
      consume(g);
    end

    // 5: reset in the middle of WAIT
    issue(0, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0000_0000_0000_00FF, "t5_grant");
    for (int i = 0; i < 6; i++) begin
      tick();
      req0_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("t5_rst_eng_vld", eng_data_vld, 0);
    check("t5_rst_rsp0", rsp0_valid, 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    req0_data = 64'h0000_1111_2222_3333; req0_key = 64'h3333_2222_1111_0000; req0_valid = 1'b1;
    wait_ready0(n, saw_rsp, saw_strobe);
    check("t5_flush_len", n, 20);
    check("t5_no_rsp", saw_rsp, 0);
    check("t5_stale_strobe", saw_strobe, 1);
    run_to_rsp(0, lat, nl);
    check("t5_latency", lat, 19);
    check("t5_data", rsp0_data, 64'h3333_3333_3333_3333);
    consume(0);

    // 6: pass-through engine instance
    c_req0_data = 64'hCAFE_F00D_1234_5678; c_req0_key = 64'h8765_4321_0000_1111; c_req0_valid = 1'b1;
    #1;
    check("t6_grant", c_req0_ready, 1);
    lat = 0;
    do begin
      tick();
      lat++;
      c_req0_valid = 1'b0;
    end while (!c_rsp0_valid && lat < 50);
    check("t6_latency", lat, 2);
    check("t6_data", c_rsp0_data, 64'hCAFE_F00D_1234_5678);
    check("t6_err", c_rsp0_err, 0);
    check("t6_rsp1", c_rsp1_valid, 0);
    c_rsp0_ready = 1'b1;
    tick();
    c_rsp0_ready = 1'b0;
    check("t6_cleared", c_rsp0_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
